// File: rtl/ecpri_pkg.sv
// Shared constants and FSM state type for the eCPRI remote-memory-access
// response path.
package ecpri_pkg;

    localparam logic [15:0] ECPRI_ETHERTYPE  = 16'hAEFE;
    localparam logic [7:0]  MSG_RMA          = 8'h04;
    localparam int          RMA_HDR_LEN      = 12;
    localparam int          ETH_HDR_LEN      = 14;
    localparam int          ECPRI_COMMON_LEN = 4;
    localparam int          FRAME_HDR_LEN    = ETH_HDR_LEN + ECPRI_COMMON_LEN + RMA_HDR_LEN;
    localparam logic [3:0]  RESP             = 4'h1;
    localparam logic        RW_READ          = 1'b0;
    localparam logic        RW_WRITE         = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ecpri_resp_tx_if.sv
// Byte-stream transmit interface towards the MAC TX FIFO.
interface ecpri_resp_tx_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_sop;
    logic                  tx_eop;
    logic                  tx_ready;

    modport master (
        output tx_data, tx_valid, tx_sop, tx_eop,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, tx_sop, tx_eop,
        output tx_ready
    );

endinterface

// File: rtl/ecpri_tx_skid.sv
// One-entry registered output stage with a single spill slot, so a RAM byte
// already in flight is never lost when the sink stalls.
module ecpri_tx_skid #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_sop_i,
    input  logic                  in_eop_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_sop_o,
    output logic                  out_eop_o,
    input  logic                  out_ready_i,
    output logic [1:0]            count_o
);

    typedef struct packed {
        logic                  sop;
        logic                  eop;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    beat_t in_beat;
    beat_t out_q, out_d;
    beat_t skid_q, skid_d;
    logic  out_valid_q, out_valid_d;
    logic  skid_valid_q, skid_valid_d;

    // The output register refills from the spill slot first to keep byte order.
    always_comb begin
        in_beat      = '{sop: in_sop_i, eop: in_eop_i, data: in_data_i};
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                if (in_valid_i) begin
                    out_d = in_beat;
                end
                out_valid_d = in_valid_i;
            end
        end else if (in_valid_i && !skid_valid_q) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q.data;
    assign out_sop_o   = out_q.sop;
    assign out_eop_o   = out_q.eop;
    assign count_o     = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/ecpri_resp_tx.sv
// Builds eCPRI Remote Memory Access response frames (header plus optional
// read payload fetched from the payload RAM) as a byte stream.
module ecpri_resp_tx
    import ecpri_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          ADDR_WIDTH = 16,
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [3:0]  ECPRI_REV  = 4'h1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_read_resp,
    input  logic                  send_write_resp,
    input  logic [7:0]            resp_payload_len,
    input  logic [7:0]            rm_acc_id,
    input  logic [15:0]           rm_ele_id,
    input  logic [47:0]           rm_addr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_data,
    ecpri_resp_tx_if.master       tx,
    output logic                  busy,
    output logic                  resp_done,
    output logic [7:0]            drop_cnt
);

    localparam logic [4:0] HDR_LAST = 5'(FRAME_HDR_LEN - 1);

    state_e      state_q, state_d;
    logic [4:0]  hdr_idx_q, hdr_idx_d;
    logic [8:0]  fetch_cnt_q, fetch_cnt_d;
    logic        inflight_q, inflight_eop_q;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        rw_q;
    logic [7:0]  len_q, acc_id_q;
    logic [15:0] ele_id_q;
    logic [47:0] addr_q;

    logic                  capture;
    logic [7:0]            pay_len;
    logic [15:0]           ecpri_size;
    logic [FRAME_HDR_LEN*8-1:0] hdr_vec;
    logic [4:0]            hdr_sel;
    logic [7:0]            hdr_byte;
    logic                  hdr_last;
    logic                  push_hdr;
    logic                  fetch_window;
    logic [2:0]            credit_used;
    logic [2:0]            credit_room;
    logic                  consumed;
    logic                  eop_accepted;
    logic [1:0]            drop_inc;
    logic [8:0]            drop_sum;

    logic                  skid_in_valid;
    logic [DATA_WIDTH-1:0] skid_in_data;
    logic                  skid_in_sop;
    logic                  skid_in_eop;
    logic                  skid_in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sop;
    logic                  out_eop;
    logic [1:0]            skid_count;

    assign capture    = (state_q == ST_IDLE) && (send_read_resp || send_write_resp);
    assign pay_len    = (rw_q == RW_READ) ? len_q : 8'd0;
    assign ecpri_size = 16'(RMA_HDR_LEN) + {8'h00, pay_len};

    assign hdr_vec = {DST_MAC, SRC_MAC, ECPRI_ETHERTYPE,
                      ECPRI_REV, 3'b000, 1'b0, MSG_RMA, ecpri_size,
                      acc_id_q, 3'b000, rw_q, RESP, ele_id_q, addr_q,
                      8'h00, len_q};

    assign hdr_sel  = (hdr_idx_q > HDR_LAST) ? HDR_LAST : hdr_idx_q;
    assign hdr_byte = hdr_vec[8*(FRAME_HDR_LEN - 1 - int'(hdr_sel)) +: 8];
    assign hdr_last = (hdr_idx_q == HDR_LAST);
    assign push_hdr = (state_q == ST_HDR) && (hdr_idx_q <= HDR_LAST) && skid_in_ready;

    assign consumed     = out_valid && tx.tx_ready;
    assign eop_accepted = consumed && out_eop;

    // A fetch is allowed only if its byte is guaranteed a slot when it returns
    // a cycle later, even if the sink stalls in between.
    assign fetch_window = (state_q == ST_PAYLOAD) || (push_hdr && hdr_last);
    assign credit_used  = {1'b0, skid_count} + {2'b00, inflight_q} + {2'b00, push_hdr};
    assign credit_room  = 3'd1 + {2'b00, consumed};
    assign ram_oe       = fetch_window && (fetch_cnt_q < {1'b0, pay_len})
                          && (credit_used <= credit_room);
    assign ram_addr     = ADDR_WIDTH'(fetch_cnt_q[7:0]);

    assign skid_in_valid = push_hdr || inflight_q;
    assign skid_in_data  = inflight_q ? ram_data : DATA_WIDTH'(hdr_byte);
    assign skid_in_sop   = push_hdr && (hdr_idx_q == 5'd0);
    assign skid_in_eop   = inflight_q ? inflight_eop_q : (hdr_last && (pay_len == 8'd0));

    ecpri_tx_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (skid_in_valid),
        .in_data_i   (skid_in_data),
        .in_sop_i    (skid_in_sop),
        .in_eop_i    (skid_in_eop),
        .in_ready_o  (skid_in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_sop_o   (out_sop),
        .out_eop_o   (out_eop),
        .out_ready_i (tx.tx_ready),
        .count_o     (skid_count)
    );

    assign tx.tx_valid = out_valid;
    assign tx.tx_data  = out_data;
    assign tx.tx_sop   = out_sop;
    assign tx.tx_eop   = out_eop;

    // Frame sequencing; zero-length frames wait in HDR until their eop drains.
    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d     = ST_HDR;
                    hdr_idx_d   = '0;
                    fetch_cnt_d = '0;
                end
            end
            ST_HDR: begin
                if (push_hdr) begin
                    hdr_idx_d = hdr_idx_q + 5'd1;
                end
                if (push_hdr && hdr_last && (pay_len != 8'd0)) begin
                    state_d = ST_PAYLOAD;
                end else if (eop_accepted) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAYLOAD: begin
                if (eop_accepted) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (ram_oe) begin
            fetch_cnt_d = fetch_cnt_q + 9'd1;
        end
    end

    assign drop_inc = (state_q == ST_IDLE) ? {1'b0, send_read_resp && send_write_resp}
                                           : {1'b0, send_read_resp} + {1'b0, send_write_resp};
    assign drop_sum   = {1'b0, drop_cnt_q} + {7'b0, drop_inc};
    assign drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            hdr_idx_q      <= '0;
            fetch_cnt_q    <= '0;
            inflight_q     <= 1'b0;
            inflight_eop_q <= 1'b0;
            drop_cnt_q     <= '0;
            rw_q           <= RW_READ;
            len_q          <= '0;
            acc_id_q       <= '0;
            ele_id_q       <= '0;
            addr_q         <= '0;
        end else begin
            state_q        <= state_d;
            hdr_idx_q      <= hdr_idx_d;
            fetch_cnt_q    <= fetch_cnt_d;
            inflight_q     <= ram_oe;
            inflight_eop_q <= (fetch_cnt_q[7:0] == (pay_len - 8'd1));
            drop_cnt_q     <= drop_cnt_d;
            if (capture) begin
                rw_q     <= send_read_resp ? RW_READ : RW_WRITE;
                len_q    <= resp_payload_len;
                acc_id_q <= rm_acc_id;
                ele_id_q <= rm_ele_id;
                addr_q   <= rm_addr;
            end
        end
    end

    assign busy      = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);
    assign resp_done = (state_q == ST_DONE);
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_ecpri_resp_tx.sv
// Scoreboard bench for ecpri_resp_tx: stimulus queues the expected frame
// bytes, a negedge monitor compares every accepted byte and RAM fetch.
module tb_ecpri_resp_tx;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        send_read_resp, send_write_resp;
    logic [7:0]  resp_payload_len, rm_acc_id;
    logic [15:0] rm_ele_id;
    logic [47:0] rm_addr;
    logic [15:0] ram_addr;
    logic        ram_oe;
    logic [7:0]  ram_data;
    logic        busy, resp_done;
    logic [7:0]  drop_cnt;

    ecpri_resp_tx_if #(.DATA_WIDTH(8)) txif ();

    ecpri_resp_tx dut (
        .clk              (clk),
        .reset            (reset),
        .send_read_resp   (send_read_resp),
        .send_write_resp  (send_write_resp),
        .resp_payload_len (resp_payload_len),
        .rm_acc_id        (rm_acc_id),
        .rm_ele_id        (rm_ele_id),
        .rm_addr          (rm_addr),
        .ram_addr         (ram_addr),
        .ram_oe           (ram_oe),
        .ram_data         (ram_data),
        .tx               (txif),
        .busy             (busy),
        .resp_done        (resp_done),
        .drop_cnt         (drop_cnt)
    );

    always #5 clk = ~clk;

    // Payload RAM model: registered read, data valid one cycle after ram_oe.
    logic [7:0] mem [0:15];
    initial ram_data = 8'h00;
    always @(posedge clk) begin
        if (ram_oe) ram_data <= mem[ram_addr[3:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t sb[$];
    int    compared = 0;
    int    mismatched = 0;
    int    pos, oe_count, exp_addr, pulse_cyc, eop_cyc;
    bit    done_seen;
    bit    bp_mode = 1'b0;
    bit    prev_stall = 1'b0;
    logic [10:0] prev_beat;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushFrame(input logic rw, input logic [7:0] len, input logic [7:0] acc,
                             input logic [15:0] ele, input logic [47:0] addr);
        logic [7:0]  b[$];
        logic [7:0]  l;
        logic [15:0] size;
        l    = rw ? 8'd0 : len;
        size = 16'd12 + {8'h00, l};
        for (int i = 0; i < 6; i++) b.push_back(8'hFF);
        b.push_back(8'h02);
        for (int i = 0; i < 4; i++) b.push_back(8'h00);
        b.push_back(8'h01);
        b.push_back(8'hAE); b.push_back(8'hFE); b.push_back(8'h10); b.push_back(8'h04);
        b.push_back(size[15:8]); b.push_back(size[7:0]);
        b.push_back(acc); b.push_back({3'b000, rw, 4'h1});
        b.push_back(ele[15:8]); b.push_back(ele[7:0]);
        for (int i = 5; i >= 0; i--) b.push_back(addr[8*i +: 8]);
        b.push_back(8'h00); b.push_back(len);
        for (int i = 0; i < int'(l); i++) b.push_back(mem[i]);
        for (int i = 0; i < b.size(); i++)
            sb.push_back('{sop: (i == 0), eop: (i == b.size() - 1), data: b[i]});
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] len,
                                 input logic [7:0] acc, input logic [15:0] ele, input logic [47:0] addr);
        @(posedge clk); #1;
        pos = 0; oe_count = 0; exp_addr = 0; done_seen = 0;
        send_read_resp = rd; send_write_resp = wr;
        resp_payload_len = len; rm_acc_id = acc; rm_ele_id = ele; rm_addr = addr;
        pulse_cyc = cyc;
        pushFrame(rd ? 1'b0 : 1'b1, len, acc, ele, addr);
        @(posedge clk); #1;
        send_read_resp = 1'b0; send_write_resp = 1'b0;
        rm_acc_id = 8'hEE; resp_payload_len = 8'hEE;
    endtask

    task automatic waitFrame(input int exp_oe, input string tag);
        int n = 0;
        while (!done_seen && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput({tag, "_done_seen"}, done_seen, 1'b1);
        checkOutput({tag, "_sb_empty"}, sb.size(), 0);
        checkOutput({tag, "_ram_oe_count"}, oe_count, exp_oe);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        tx_ready_init();
    end

    task automatic tx_ready_init();
        txif.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            txif.tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    // Monitor: byte order/content, hold-while-stalled, sop latency, RAM fetch order.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall)
                checkOutput("hold_stable", {txif.tx_valid, txif.tx_sop, txif.tx_eop, txif.tx_data}, prev_beat);
            if (txif.tx_valid && txif.tx_sop && !prev_stall)
                checkOutput("sop_latency", cyc - pulse_cyc, 2);
            if (txif.tx_valid && txif.tx_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_byte", {txif.tx_sop, txif.tx_eop, txif.tx_data}, 11'h7FF);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    checkOutput($sformatf("byte%0d", pos), {txif.tx_sop, txif.tx_eop, txif.tx_data}, e);
                end
                if (txif.tx_eop) eop_cyc = cyc;
                pos++;
            end
            if (ram_oe) begin
                checkOutput("ram_addr", ram_addr, exp_addr);
                exp_addr++;
                oe_count++;
            end
            if (oe_count > 0)
                checkOutput("outstanding_le2", (oe_count - ((pos > 30) ? pos - 30 : 0)) <= 2, 1'b1);
            if (resp_done) begin
                checkOutput("done_timing", cyc, eop_cyc + 1);
                checkOutput("busy_at_done", busy, 1'b0);
                done_seen = 1'b1;
            end
            prev_stall = txif.tx_valid && !txif.tx_ready;
            prev_beat  = {txif.tx_valid, txif.tx_sop, txif.tx_eop, txif.tx_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4; mem[4] = 8'hE5;
        for (int i = 5; i < 16; i++) mem[i] = 8'(i);
        reset = 1'b1;
        send_read_resp = 1'b0; send_write_resp = 1'b0;
        resp_payload_len = 8'h00; rm_acc_id = 8'h00; rm_ele_id = 16'h0; rm_addr = 48'h0;
        pos = 0; oe_count = 0; exp_addr = 0; pulse_cyc = 0; eop_cyc = 0; done_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", {txif.tx_valid, txif.tx_sop, txif.tx_eop, txif.tx_data,
                                    busy, resp_done, ram_oe, ram_addr, drop_cnt}, '0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] write response len=4");
        applyStimulus(1'b0, 1'b1, 8'd4, 8'h5A, 16'h0102, 48'h0000_1000_0020);
        waitFrame(0, "write");

        $display("[TB] read response len=3");
        applyStimulus(1'b1, 1'b0, 8'd3, 8'h33, 16'hBEEF, 48'h0102_0304_0506);
        waitFrame(3, "read3");

        $display("[TB] read response len=5 with backpressure");
        bp_mode = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'd5, 8'h77, 16'h1234, 48'hAABB_CCDD_EEFF);
        waitFrame(5, "bp5");
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] collision and mid-frame drop");
        applyStimulus(1'b1, 1'b1, 8'd2, 8'h42, 16'h4242, 48'h0000_0000_4242);
        repeat (5) @(posedge clk);
        #1;
        send_read_resp = 1'b1; rm_acc_id = 8'h99; resp_payload_len = 8'd9;
        @(posedge clk); #1;
        send_read_resp = 1'b0;
        waitFrame(2, "collision");
        checkOutput("drop_cnt", drop_cnt, 8'd2);

        $display("[TB] zero-length read");
        applyStimulus(1'b1, 1'b0, 8'd0, 8'h01, 16'h0001, 48'h0000_0000_0001);
        waitFrame(0, "zero_len");

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 1'b0, 8'd5, 8'h55, 16'h5555, 48'h5555_5555_5555);
        n = 0;
        while (pos < 32 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("reached_payload2", pos >= 32, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("reset_midframe", {txif.tx_valid, txif.tx_sop, txif.tx_eop, txif.tx_data,
                                       busy, resp_done, ram_oe, ram_addr, drop_cnt}, '0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] write response after reset");
        applyStimulus(1'b0, 1'b1, 8'd7, 8'hC0, 16'hCAFE, 48'h1122_3344_5566);
        waitFrame(0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
